// File: rtl/mem_skew_buf_pkg.sv
// Shared types and sizing helpers for the skewed A-operand staging buffer.
// Optional ping-pong banking is enabled by defining MEM_SKEW_DBUF_EN.
package mem_skew_pkg;

  // Streaming controller states
  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Width of the beat counter covering 0 .. 2*DIM-2
  function automatic int cnt_w(input int dim);
    return $clog2(2 * dim - 1);
  endfunction

  // Index of the final beat of a stream
  function automatic int last_t(input int dim);
    return 2 * dim - 2;
  endfunction

endpackage

// File: rtl/mem_skew_buf_bank.sv
// One DIM x DIM bank of signed elements with a single row-wide write port
// and DIM independent combinational element reads (one per output row).
// A row whose read select is low returns zero instead of a stored element.
module mem_skew_bank
  import mem_skew_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [$clog2(DIM)-1:0]       wrow,
  input  logic [DIM*BITS_AB-1:0]       wdata,
  input  logic [DIM*$clog2(DIM)-1:0]   rcol,
  input  logic [DIM-1:0]               rsel,
  output logic [DIM*BITS_AB-1:0]       rdata
);

  localparam int IDX_W = $clog2(DIM);

  typedef logic signed [BITS_AB-1:0] elem_t;

  elem_t mem_reg [DIM][DIM];

  // Row write; reset clears the whole bank so a fresh stream reads zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mem_reg[r][c] <= '0;
        end
      end
    end else if (we) begin
      for (int c = 0; c < DIM; c++) begin
        mem_reg[wrow][c] <= elem_t'(wdata[c*BITS_AB +: BITS_AB]);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_rd
      assign rdata[gi*BITS_AB +: BITS_AB] =
        rsel[gi] ? mem_reg[gi][rcol[gi*IDX_W +: IDX_W]] : '0;
    end
  endgenerate

endmodule

// File: rtl/mem_skew_buf.sv
// Skewed A-operand staging buffer: rows are loaded by index, then streamed
// so that array row r sees A[r][k] on beat k+r and zero elsewhere.
// Define MEM_SKEW_DBUF_EN for two ping-pong banks (load one while the
// other streams); otherwise a single bank that only accepts writes in IDLE.
module mem_skew_buf
  import mem_skew_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   WrEn,
  input  logic [$clog2(DIM)-1:0] Arow,
  input  logic [DIM*BITS_AB-1:0] Ain,
  input  logic                   start,
  input  logic                   en,
  output logic [DIM*BITS_AB-1:0] Aout,
  output logic                   Avalid,
  output logic                   busy,
  output logic                   done
);

  localparam int                IDX_W   = $clog2(DIM);
  localparam int                CNT_W   = cnt_w(DIM);
  localparam logic [CNT_W-1:0]  LAST_T  = CNT_W'(last_t(DIM));
  localparam logic [CNT_W:0]    COL_MAX = (CNT_W + 1)'(DIM - 1);

  state_t                 state_reg;
  logic [CNT_W-1:0]       t_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   avalid_reg;
  logic [DIM*BITS_AB-1:0] aout_reg;

  logic [DIM*IDX_W-1:0]   rcol;
  logic [DIM-1:0]         rsel;
  logic [DIM*BITS_AB-1:0] rdata;

  genvar gi;

  // Per-row column index t-r, kept one bit wider so negative values are
  // recognisable; out-of-range rows are zero-selected rather than wrapped.
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_idx
      localparam logic [CNT_W:0] ROW = (CNT_W + 1)'(gi);
      logic [CNT_W:0] diff;
      assign diff                     = {1'b0, t_reg} - ROW;
      assign rsel[gi]                 = !diff[CNT_W] && (diff <= COL_MAX);
      assign rcol[gi*IDX_W +: IDX_W]  = diff[IDX_W-1:0];
    end
  endgenerate

`ifdef MEM_SKEW_DBUF_EN
  logic                   wb_reg;
  logic                   sb_reg;
  logic [DIM*BITS_AB-1:0] bank_rdata [2];

  // Writes always target the write bank, even mid-stream
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      mem_skew_bank #(
        .BITS_AB (BITS_AB),
        .DIM     (DIM)
      ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (WrEn && (wb_reg == 1'(gi))),
        .wrow  (Arow),
        .wdata (Ain),
        .rcol  (rcol),
        .rsel  (rsel),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  assign rdata = sb_reg ? bank_rdata[1] : bank_rdata[0];
`else
  // Single bank: storage is frozen while a stream is in flight
  mem_skew_bank #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (WrEn && (state_reg == IDLE)),
    .wrow  (Arow),
    .wdata (Ain),
    .rcol  (rcol),
    .rsel  (rsel),
    .rdata (rdata)
  );
`endif

  // Stream controller: beat counter, handshake flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      t_reg      <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      avalid_reg <= 1'b0;
      aout_reg   <= '0;
`ifdef MEM_SKEW_DBUF_EN
      wb_reg     <= 1'b0;
      sb_reg     <= 1'b0;
`endif
    end else begin
      done_reg   <= 1'b0;
      avalid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= STREAM;
            t_reg     <= '0;
            busy_reg  <= 1'b1;
`ifdef MEM_SKEW_DBUF_EN
            sb_reg    <= wb_reg;
            wb_reg    <= ~wb_reg;
`endif
          end
        end
        STREAM: begin
          if (en) begin
            aout_reg   <= rdata;
            avalid_reg <= 1'b1;
            if (t_reg == LAST_T) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              t_reg <= t_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Aout   = aout_reg;
  assign Avalid = avalid_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_mem_skew_buf.sv
// Self-checking bench for mem_skew_buf (DIM=8, BITS_AB=8). The reference
// keeps the stored matrix (two banks when MEM_SKEW_DBUF_EN is defined),
// snapshots it when a stream is accepted and pops skewed beats from it.
module tb_mem_skew_buf;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int W       = DIM * BITS_AB;
  localparam int NB      = 2 * DIM - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         WrEn = 1'b0;
  logic [2:0]   Arow = '0;
  logic [W-1:0] Ain = '0;
  logic         start = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] Aout;
  logic         Avalid;
  logic         busy;
  logic         done;

  mem_skew_buf #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .WrEn   (WrEn),
    .Arow   (Arow),
    .Ain    (Ain),
    .start  (start),
    .en     (en),
    .Aout   (Aout),
    .Avalid (Avalid),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  int           bank [2][DIM][DIM];
  int           snap [DIM][DIM];
  int           wb = 0;
  bit           m_busy = 1'b0;
  int           m_k = 0;
  logic [W-1:0] exp_aout = '0;
  bit           exp_valid = 1'b0;
  bit           exp_done = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Beat k of the snapshot: row r carries A[r][k-r] when that column exists
  function automatic logic [W-1:0] beat(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < DIM; r++) begin
      int c;
      c = k - r;
      if (c >= 0 && c < DIM) v[r*BITS_AB +: BITS_AB] = BITS_AB'(snap[r][c]);
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) bank[b][r][c] = 0;
    wb = 0; m_busy = 1'b0; m_k = 0;
    exp_aout = '0; exp_valid = 1'b0; exp_done = 1'b0;
  endtask

  // Apply the rules for one rising edge using the currently driven inputs
  task automatic model_edge();
    bit was_busy;
    bit accept;
    was_busy  = m_busy;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (was_busy && en) begin
      exp_aout  = beat(m_k);
      exp_valid = 1'b1;
      m_k++;
      if (m_k == NB) begin
        m_busy   = 1'b0;
        exp_done = 1'b1;
      end
    end
`ifdef MEM_SKEW_DBUF_EN
    accept = WrEn;
`else
    accept = WrEn && !was_busy;
`endif
    if (accept)
      for (int c = 0; c < DIM; c++)
        bank[wb][Arow][c] = int'($signed(Ain[c*BITS_AB +: BITS_AB]));
    if (!was_busy && start) begin
      snap   = bank[wb];
      m_busy = 1'b1;
      m_k    = 0;
`ifdef MEM_SKEW_DBUF_EN
      wb = 1 - wb;
`endif
    end
  endtask

  task automatic drive(input bit we, input int row, input logic [W-1:0] d,
                       input bit st, input bit e);
    WrEn = we; Arow = 3'(row); Ain = d; start = st; en = e;
  endtask

  // One clock: model the edge, then compare on the falling edge
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".avalid"}, W'(Avalid), W'(exp_valid));
    chk({tag, ".busy"},   W'(busy),   W'(m_busy));
    chk({tag, ".done"},   W'(done),   W'(exp_done));
    if (exp_valid || m_busy) chk({tag, ".aout"}, Aout, exp_aout);
  endtask

  function automatic logic [W-1:0] row_of(input int r);
    logic [W-1:0] v;
    for (int c = 0; c < DIM; c++) v[c*BITS_AB +: BITS_AB] = BITS_AB'(8 * r + c + 1);
    return v;
  endfunction

  function automatic logic [W-1:0] rand_row(input bit extremes);
    logic [W-1:0] v;
    for (int c = 0; c < DIM; c++) begin
      int sel;
      sel = extremes ? int'($urandom_range(0, 2)) : 2;
      v[c*BITS_AB +: BITS_AB] = (sel == 0) ? 8'h80 : (sel == 1) ? 8'h7F : 8'($urandom);
    end
    return v;
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, ".aout"},   Aout,       '0);
    chk({tag, ".avalid"}, W'(Avalid), '0);
    chk({tag, ".busy"},   W'(busy),   '0);
    chk({tag, ".done"},   W'(done),   '0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;

    // Idle, then a stream of an empty matrix
    drive(0, 0, '0, 0, 0);
    repeat (2) cycle("idle");
    drive(0, 0, '0, 1, 1);
    cycle("start0");
    drive(0, 0, '0, 0, 1);
    repeat (NB + 2) cycle("zeros");

    // Load A[r][c] = 8r+c+1 and stream with en held high
    for (int r = 0; r < DIM; r++) begin
      drive(1, r, row_of(r), 0, 0);
      cycle("load");
    end
    drive(0, 0, '0, 1, 1);
    cycle("start1");
    drive(0, 0, '0, 0, 1);
    repeat (NB + 2) cycle("ramp");

    // Same data, en pattern 1,0,0 repeating
    drive(0, 0, '0, 1, 0);
    cycle("start2");
    for (int i = 0; i < 3 * NB + 4; i++) begin
      drive(0, 0, '0, 0, (i % 3) == 0);
      cycle("stall");
    end

    // Writes to row 3 while streaming, then stream again
    drive(0, 0, '0, 1, 1);
    cycle("start3");
    for (int i = 0; i < NB + 2; i++) begin
      drive(i < 4, 3, {DIM{8'h7F}}, 0, 1);
      cycle("wrbusy");
    end
    drive(0, 0, '0, 1, 1);
    cycle("start4");
    drive(0, 0, '0, 0, 1);
    repeat (NB + 2) cycle("after_wr");

    // Asynchronous reset after beat 5 of a stream
    drive(0, 0, '0, 1, 1);
    cycle("start5");
    drive(0, 0, '0, 0, 1);
    repeat (6) cycle("pre_rst");
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, '0, 1, 1);
    cycle("start6");
    drive(0, 0, '0, 0, 1);
    repeat (NB + 2) cycle("post_rst");

    // Signed extremes with start held high: back-to-back streams
    for (int r = 0; r < DIM; r++) begin
      drive(1, r, rand_row(1'b1), 0, 0);
      cycle("load_ext");
    end
    drive(0, 0, '0, 1, 1);
    repeat (3 * (NB + 1) + 3) cycle("b2b");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, int'($urandom_range(0, DIM - 1)), rand_row(1'b1),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
